// File: rtl/seq_ext_monitor.sv
`default_nettype none
// ============================================================================
// Module   : seq_ext_monitor
// Brief    : Multi-channel monitor for "a ##1 b ##EXT 1" with match/fail
//            pulses and saturating per-channel counters.
//            Optional: SEQ_EXT_MON_TSTAMP_EN adds last-match timestamp/channel.
// Revision : 1.0 - initial release
// ============================================================================
module seq_ext_monitor #(
    parameter int NCH   = 4,
    parameter int EXT   = 2,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [NCH-1:0]       a_i,
    input  logic [NCH-1:0]       b_i,
    output logic [NCH-1:0]       match_o,
    output logic [NCH-1:0]       fail_o,
    output logic [NCH*CNT_W-1:0] match_cnt_o,
    output logic [NCH*CNT_W-1:0] fail_cnt_o,
    output logic                 busy_o
`ifdef SEQ_EXT_MON_TSTAMP_EN
    ,
    output logic [TS_W-1:0]                      last_ts_o,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] last_ch_o
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = 1;

    logic [NCH-1:0] w_busy_ch;
    logic [NCH-1:0] w_match_nxt;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic             r_a_q;
        logic             r_match;
        logic             r_fail;
        logic [CNT_W-1:0] r_mcnt;
        logic [CNT_W-1:0] r_fcnt;
        logic             w_pass;
        logic             w_fail_nxt;
        logic             w_pend_any;
        logic             w_m_nxt;

        assign w_pass     = r_a_q & b_i[c];
        assign w_fail_nxt = r_a_q & ~b_i[c];

        // Each passing attempt owns one slot of the delay line, so overlapping
        // attempts never merge.
        if (EXT == 0) begin : g_ext0
            assign w_m_nxt    = w_pass;
            assign w_pend_any = 1'b0;
        end else if (EXT == 1) begin : g_ext1
            logic r_pend;
            always_ff @(posedge clk) begin
                if (!rst_n || clr_i) r_pend <= 1'b0;
                else                 r_pend <= w_pass;
            end
            assign w_m_nxt    = r_pend;
            assign w_pend_any = r_pend;
        end else begin : g_extn
            logic [EXT-1:0] r_pend;
            always_ff @(posedge clk) begin
                if (!rst_n || clr_i) r_pend <= '0;
                else                 r_pend <= {r_pend[EXT-2:0], w_pass};
            end
            assign w_m_nxt    = r_pend[EXT-1];
            assign w_pend_any = |r_pend;
        end

        always_ff @(posedge clk) begin
            if (!rst_n || clr_i) begin
                r_a_q   <= 1'b0;
                r_match <= 1'b0;
                r_fail  <= 1'b0;
                r_mcnt  <= '0;
                r_fcnt  <= '0;
            end else begin
                r_a_q   <= en_i & a_i[c];
                r_match <= w_m_nxt;
                r_fail  <= w_fail_nxt;
                if (w_m_nxt && (r_mcnt != '1))
                    r_mcnt <= r_mcnt + c_CNT_ONE;
                if (w_fail_nxt && (r_fcnt != '1))
                    r_fcnt <= r_fcnt + c_CNT_ONE;
            end
        end

        assign match_o[c]                    = r_match;
        assign fail_o[c]                     = r_fail;
        assign match_cnt_o[c*CNT_W +: CNT_W] = r_mcnt;
        assign fail_cnt_o[c*CNT_W +: CNT_W]  = r_fcnt;
        assign w_busy_ch[c]                  = r_a_q | w_pend_any;
        assign w_match_nxt[c]                = w_m_nxt;
    end

    assign busy_o = |w_busy_ch;

`ifdef SEQ_EXT_MON_TSTAMP_EN
    localparam int            c_CHW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [TS_W-1:0] c_TS_ONE = 1;

    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_last_ts;
    logic [c_CHW-1:0] r_last_ch;
    logic [c_CHW-1:0] w_low_ch;

    // Descending scan so the lowest matching channel is the last one written.
    always_comb begin
        w_low_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_match_nxt[i]) w_low_ch = c_CHW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts      <= '0;
            r_last_ts <= '0;
            r_last_ch <= '0;
        end else if (clr_i) begin
            r_ts      <= '0;
        end else begin
            r_ts <= r_ts + c_TS_ONE;
            if (|w_match_nxt) begin
                r_last_ts <= r_ts;
                r_last_ch <= w_low_ch;
            end
        end
    end

    assign last_ts_o = r_last_ts;
    assign last_ch_o = r_last_ch;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_ext_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_ext_monitor
// Brief    : Directed self-checking bench; dut0 uses EXT=2/CNT_W=8,
//            dut1 uses EXT=0/CNT_W=2 for zero-extension and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ext_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en0, clr0, en1, clr1;
    logic [3:0]  a0, b0, a1, b1;
    logic [3:0]  match0, fail0, match1, fail1;
    logic [31:0] mcnt0, fcnt0;
    logic [7:0]  mcnt1, fcnt1;
    logic        busy0, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_ext_monitor #(.NCH(4), .EXT(2), .CNT_W(8), .TS_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .en_i(en0), .clr_i(clr0),
        .a_i(a0), .b_i(b0), .match_o(match0), .fail_o(fail0),
        .match_cnt_o(mcnt0), .fail_cnt_o(fcnt0), .busy_o(busy0)
    );

    seq_ext_monitor #(.NCH(4), .EXT(0), .CNT_W(2), .TS_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .en_i(en1), .clr_i(clr1),
        .a_i(a1), .b_i(b1), .match_o(match1), .fail_o(fail1),
        .match_cnt_o(mcnt1), .fail_cnt_o(fcnt1), .busy_o(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after the active edge; outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en0 = 1'b1; clr0 = 1'b1; a0 = 4'hF; b0 = 4'hF;
        en1 = 1'b1; clr1 = 1'b0; a1 = 4'hF; b1 = 4'hF;
        tick(); tick(); tick();
        chk("rst_match",  {60'd0, match0}, 64'd0);
        chk("rst_fail",   {60'd0, fail0},  64'd0);
        chk("rst_mcnt",   {32'd0, mcnt0},  64'd0);
        chk("rst_fcnt",   {32'd0, fcnt0},  64'd0);
        chk("rst_busy",   {63'd0, busy0},  64'd0);
        chk("rst_mcnt1",  {56'd0, mcnt1},  64'd0);

        rst_n = 1'b1; clr0 = 1'b0; a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
        tick();

        // ch0 pass, ch1 fail, ch2 three back-to-back passes
        a0 = 4'b0111; b0 = 4'b0000; tick();            // edge 1
        chk("e1_busy",  {63'd0, busy0},  64'd1);
        chk("e1_fail",  {60'd0, fail0},  64'd0);
        a0 = 4'b0100; b0 = 4'b0101; tick();            // edge 2
        chk("e2_fail",  {60'd0, fail0},  64'b0010);
        chk("e2_match", {60'd0, match0}, 64'd0);
        a0 = 4'b0100; b0 = 4'b0100; tick();            // edge 3
        chk("e3_fail",  {60'd0, fail0},  64'd0);
        chk("e3_match", {60'd0, match0}, 64'd0);
        chk("e3_busy",  {63'd0, busy0},  64'd1);
        a0 = 4'b0000; b0 = 4'b0100; tick();            // edge 4
        chk("e4_match", {60'd0, match0}, 64'b0101);
        a0 = 4'b0000; b0 = 4'b0000; tick();            // edge 5
        chk("e5_match", {60'd0, match0}, 64'b0100);
        tick();                                        // edge 6
        chk("e6_match", {60'd0, match0}, 64'b0100);
        chk("e6_busy",  {63'd0, busy0},  64'd0);
        tick();                                        // edge 7
        chk("e7_match", {60'd0, match0}, 64'd0);
        chk("cnt_match", {32'd0, mcnt0}, 64'h0003_0001);
        chk("cnt_fail",  {32'd0, fcnt0}, 64'h0000_0100);

        // clr kills a pending ch0 match, a ch3 fail and a ch1 start
        a0 = 4'b0001; tick();
        a0 = 4'b1000; b0 = 4'b0001; tick();
        a0 = 4'b0010; b0 = 4'b0000; clr0 = 1'b1; tick();
        chk("clr_busy",  {63'd0, busy0},  64'd0);
        chk("clr_fail",  {60'd0, fail0},  64'd0);
        chk("clr_mcnt",  {32'd0, mcnt0},  64'd0);
        chk("clr_fcnt",  {32'd0, fcnt0},  64'd0);
        a0 = 4'b0000; clr0 = 1'b0; tick();
        chk("clr_nomatch", {60'd0, match0}, 64'd0);
        chk("clr_nofail",  {60'd0, fail0},  64'd0);
        tick(); tick();
        chk("clr_nomatch2", {60'd0, match0}, 64'd0);

        // en low blocks a start
        en0 = 1'b0; a0 = 4'b0001; tick();
        chk("en_busy", {63'd0, busy0}, 64'd0);
        en0 = 1'b1; a0 = 4'b0000; tick();
        chk("en_fail", {60'd0, fail0}, 64'd0);
        tick(); tick();
        chk("en_match", {60'd0, match0}, 64'd0);
        chk("en_cnt",   {32'd0, mcnt0 | fcnt0}, 64'd0);

        // EXT=0: a at edge e, b at e+1 -> match registered at e+1
        a1 = 4'b0001; tick();
        chk("x0_early", {60'd0, match1}, 64'd0);
        a1 = 4'b0000; b1 = 4'b0001; tick();
        chk("x0_match", {60'd0, match1}, 64'b0001);
        b1 = 4'b0000; tick();
        chk("x0_pulse", {60'd0, match1}, 64'd0);

        // CNT_W=2 saturation: six passing sequences on ch3
        a1 = 4'b1000; b1 = 4'b1000;
        for (int i = 0; i < 7; i++) tick();
        a1 = 4'b0000; b1 = 4'b0000; tick();
        chk("sat_cnt",  {56'd0, mcnt1}, 64'b11_00_00_01);
        clr1 = 1'b1; tick();
        clr1 = 1'b0;
        chk("sat_clr",  {56'd0, mcnt1}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_ext_monitor.md
Name: seq_ext_monitor

Overview:
- Synthesizable multi-channel monitor for the temporal pattern "a ##1 b ##EXT 1": `a`, then `b` on the next cycle, then an unconditional extension of EXT cycles.
- Emits per-channel match and fail pulses and keeps saturating match/fail counters.
- Used in hardware as a silicon-side counterpart of the equivalent assertion.
- Sits beside the DUT, observes handshake-like signal pairs and feeds status/debug registers.

Parameters:
- NCH, 4, number of independent channels (1..32)
- EXT, 2, unconditional extension in clock cycles after `b` (0..15)
- CNT_W, 8, width of each per-channel saturating counter (2..32)
- TS_W, 16, timestamp width (used only with the optional feature)

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- en_i  in  1  attempt enable; low blocks new attempts, in-flight attempts continue
- clr_i  in  1  synchronous clear of counters and in-flight attempts
- a_i  in  NCH  per-channel antecedent `a`
- b_i  in  NCH  per-channel consequent `b`
- match_o  out  NCH  one-cycle pulse per completed sequence
- fail_o  out  NCH  one-cycle pulse when `a` was not followed by `b`
- match_cnt_o  out  NCH*CNT_W  packed per-channel match counters; channel i in bits [i*CNT_W +: CNT_W]
- fail_cnt_o  out  NCH*CNT_W  packed per-channel fail counters, same packing
- busy_o  out  1  OR of all in-flight attempt state across channels

Behaviour:
- Reset: rst_n low at a posedge zeroes every register. Outputs match_o, fail_o, match_cnt_o, fail_cnt_o and busy_o all read 0. Reset overrides clr_i and all other inputs.
- Edge numbering: edges are numbered k, k+1, …. An attempt starts at edge k when en_i && a_i[c]; it is captured in a_q[c].
- Edge k+1 evaluation:
  - a_q[c] && b_i[c]: attempt passes.
    - EXT=0: match_o[c] registered high at edge k+1.
    - EXT>0: pend[c][0] set.
  - a_q[c] && !b_i[c]: fail_o[c] registered high at edge k+1 for exactly one cycle.
- Extension: pend[c] is an EXT-bit shift register advancing every edge, independent of a_i, b_i and en_i. match_o[c] is registered from pend[c][EXT-1], so the match pulse is registered at edge k+1+EXT.
- Overlap: a new attempt may start every cycle. Each attempt occupies its own pend position, so back-to-back `a` produce back-to-back outputs with no loss and no merging.
- Same-cycle `b`: a `b` that closes attempt k may also be the next cycle's `a` sample for that channel; both are evaluated independently.
- Counters:
  - match_cnt[c] increments at the edge match_o[c] is registered high.
  - fail_cnt[c] increments at the edge fail_o[c] is registered high.
  - Both saturate at all-ones and never wrap.
- clr_i high at an edge:
  - zeroes a_q, pend, both counters and match_o/fail_o (pulses read 0 in the following cycle);
  - suppresses any attempt start at that edge;
  - wins over a simultaneous increment.
- en_i low at edge k: no attempt starts. Attempts already in a_q or pend complete normally.
- busy_o = OR over channels of (a_q | pend), combinational from registers.
- Channels are fully independent; no arbitration between them.

Optional Feature:
- Macro SEQ_EXT_MON_TSTAMP_EN.
- Defined:
  - Adds a free-running TS_W-bit cycle counter, zeroed by reset and clr_i, wrapping modulo 2^TS_W.
  - Adds output last_ts_o [TS_W], capturing the counter value at the edge any match_o bit is registered high.
  - Adds output last_ch_o [$clog2(NCH)] (1 bit when NCH=1); on simultaneous matches the lowest channel index is captured.
  - Both outputs reset to 0.
- Undefined: these ports, the counter and the capture logic do not exist; all other behaviour is identical.

Test Plan:
- EXT=2, ch0: a=1 at edge 1, b=1 at edge 2 → match_o[0] registered at edge 4 for one cycle; match_cnt ch0=1; fail_o stays 0; busy_o high from after edge 1 through edge 3.
- ch1: a=1 at edge 1, b=0 at edge 2 → fail_o[1] registered at edge 2 for one cycle; fail_cnt ch1=1; no match.
- Back-to-back on ch2: a=1 at edges 1,2,3 and b=1 at edges 2,3,4 → match_o[2] high after edges 4,5,6 (three consecutive cycles); match_cnt ch2=3.
- CNT_W=2: six passing sequences on ch3 → match_cnt ch3 holds 3 (saturated); then clr_i at an edge → counter reads 0 after that edge.
- clr_i asserted at edge 3 with an ch0 attempt pending from edges 1/2 → no match_o at edge 4; busy_o reads 0 after edge 3. Separately, en_i=0 at edge 1 with a=1 → no attempt, no pulses.
- EXT=0 build: a at edge 5, b at edge 6 → match_o registered at edge 6. With SEQ_EXT_MON_TSTAMP_EN and simultaneous ch1/ch3 matches → last_ch_o=1 and last_ts_o equals the timestamp count at that edge.
